// File: rtl/maze_game_ctrl.sv
// Frame-rate game sequencer: ball position, lives, map selection and game-phase flags.
// Decisions are taken on frame_tick edges; start-driven transitions act on any edge.
module maze_game_ctrl #(
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned BALL_R       = 8,
    parameter int unsigned START_ROW    = 24,
    parameter int unsigned START_COL    = 24,
    parameter int unsigned STEP         = 2,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned COUNT_FRAMES = 180,
    parameter int unsigned DELAY_FRAMES = 60
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic [1:0]  collision,
    input  logic [1:0]  touchdown,
    output logic [31:0] currentBallRow,
    output logic [31:0] currentBallCol,
    output logic        countdown,
    output logic        isdelay,
    output logic        win,
    output logic        lose,
    output logic        change,
    output logic        map_switch,
    output logic [1:0]  lives
);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNTDOWN, S_PLAY, S_DELAY, S_WIN, S_LOSE
    } state_t;

    localparam logic [31:0] POS_MIN  = 32'(BALL_R);
    localparam logic [31:0] ROW_MAX  = 32'(SCREEN_H - 1 - BALL_R);
    localparam logic [31:0] COL_MAX  = 32'(SCREEN_W - 1 - BALL_R);
    localparam logic [31:0] STEP_W   = 32'(STEP);
    localparam logic [31:0] ROW_INIT = 32'(START_ROW);
    localparam logic [31:0] COL_INIT = 32'(START_COL);
    localparam logic [1:0]  LIV_INIT = 2'(LIVES);
    localparam logic [7:0]  CNT_LAST = 8'(COUNT_FRAMES - 1);
    localparam logic [7:0]  DLY_LAST = 8'(DELAY_FRAMES - 1);

    state_t      state_q, state_d;
    logic [31:0] row_q, row_d, col_q, col_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        map_q, map_d;
    logic        change_q, change_d;
    logic        hit_q, hit_d, tdn_q, tdn_d;
    logic        armed_q, armed_d;
    logic        hit_now, tdn_now;
    logic        unused_bits;

    assign unused_bits = collision[1] ^ touchdown[1];

    // Low side compares before subtracting so the unsigned register never wraps.
    function automatic logic [31:0] step_pos(input logic [31:0] p, input logic dec,
                                             input logic inc, input logic [31:0] hi);
        logic [31:0] r;
        r = p;
        if (dec && !inc)
            r = (p < POS_MIN + STEP_W) ? POS_MIN : p - STEP_W;
        else if (inc && !dec)
            r = (p + STEP_W > hi) ? hi : p + STEP_W;
        return r;
    endfunction

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            row_q    <= ROW_INIT;
            col_q    <= COL_INIT;
            lives_q  <= LIV_INIT;
            cnt_q    <= '0;
            map_q    <= 1'b0;
            change_q <= 1'b0;
            hit_q    <= 1'b0;
            tdn_q    <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            lives_q  <= lives_d;
            cnt_q    <= cnt_d;
            map_q    <= map_d;
            change_q <= change_d;
            hit_q    <= hit_d;
            tdn_q    <= tdn_d;
            armed_q  <= armed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        map_d   = map_q;
        armed_d = armed_q;
        hit_d   = 1'b0;
        tdn_d   = 1'b0;
        hit_now = hit_q | collision[0];
        tdn_now = tdn_q | touchdown[0];

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_COUNTDOWN;
                    cnt_d   = '0;
                end
            end
            S_COUNTDOWN: begin
                if (frame_tick) begin
                    if (cnt_q == CNT_LAST) state_d = S_PLAY;
                    else                   cnt_d   = cnt_q + 8'd1;
                end
            end
            S_PLAY: begin
                if (!frame_tick) begin
                    hit_d = hit_now;
                    tdn_d = tdn_now;
                end else if (hit_now) begin
                    lives_d = lives_q - 2'd1;
                    row_d   = ROW_INIT;
                    col_d   = COL_INIT;
                    if (lives_q == 2'd1) begin
                        state_d = S_LOSE;
                        armed_d = 1'b0;
                    end else begin
                        state_d = S_DELAY;
                        cnt_d   = '0;
                    end
                end else if (tdn_now) begin
                    state_d = S_WIN;
                    armed_d = 1'b0;
                end else begin
                    row_d = step_pos(row_q, btn_up, btn_down, ROW_MAX);
                    col_d = step_pos(col_q, btn_left, btn_right, COL_MAX);
                end
            end
            S_DELAY: begin
                if (frame_tick) begin
                    if (cnt_q == DLY_LAST) state_d = S_PLAY;
                    else                   cnt_d   = cnt_q + 8'd1;
                end
            end
            S_WIN, S_LOSE: begin
                // Restart is armed only once start has been seen low on the end screen.
                if (!start) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = S_COUNTDOWN;
                    cnt_d   = '0;
                    lives_d = LIV_INIT;
                    row_d   = ROW_INIT;
                    col_d   = COL_INIT;
                    if (state_q == S_WIN) map_d = ~map_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        change_d = (row_d != row_q) || (col_d != col_q);
    end

    assign currentBallRow = row_q;
    assign currentBallCol = col_q;
    assign countdown      = (state_q == S_COUNTDOWN);
    assign isdelay        = (state_q == S_DELAY);
    assign win            = (state_q == S_WIN);
    assign lose           = (state_q == S_LOSE);
    assign change         = change_q;
    assign map_switch     = map_q;
    assign lives          = lives_q;

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Scoreboard bench for maze_game_ctrl: each stimulus cycle queues its expected outputs,
// which are popped and compared one cycle later. COUNT_FRAMES=4, DELAY_FRAMES=3.
module tb_maze_game_ctrl;

    logic        pixel_clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_tick = 1'b0, start = 1'b0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [1:0]  collision = '0, touchdown = '0;
    logic [31:0] currentBallRow, currentBallCol;
    logic        countdown, isdelay, win, lose, change, map_switch;
    logic [1:0]  lives;
    logic [71:0] obs;

    // Stimulus bits: {tick, start, up, down, left, right, collision0, touchdown0}
    localparam logic [7:0] N = 8'h00, T = 8'h80, S = 8'h40, U = 8'h20, D = 8'h10;
    localparam logic [7:0] L = 8'h08, R = 8'h04, C = 8'h02, W = 8'h01;
    localparam logic [71:0] FULL  = '1;
    localparam logic [71:0] NOCHG = ~72'h2;

    typedef struct {
        string       name;
        logic [7:0]  in;
        logic [71:0] v;
        logic [71:0] mask;
    } stim_t;

    stim_t       exp_q[$];
    int unsigned n_chk = 0, n_pass = 0;

    maze_game_ctrl #(.COUNT_FRAMES(4), .DELAY_FRAMES(3)) dut (
        .pixel_clk(pixel_clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .collision(collision), .touchdown(touchdown),
        .currentBallRow(currentBallRow), .currentBallCol(currentBallCol),
        .countdown(countdown), .isdelay(isdelay), .win(win), .lose(lose),
        .change(change), .map_switch(map_switch), .lives(lives)
    );

    always #5 pixel_clk = ~pixel_clk;

    assign obs = {currentBallRow, currentBallCol, lives,
                  countdown, isdelay, win, lose, change, map_switch};

    // flags = {countdown, isdelay, win, lose, change, map_switch}
    function automatic logic [71:0] mk(input int unsigned r, input int unsigned c,
                                       input logic [1:0] l, input logic [5:0] f);
        return {32'(r), 32'(c), l, f};
    endfunction

    task automatic apply(input logic [7:0] in);
        {frame_tick, start, btn_up, btn_down, btn_left, btn_right} = in[7:2];
        collision = {1'b0, in[1]};
        touchdown = {1'b0, in[0]};
    endtask

    task automatic test_reset();
        stim_t s[$];
        stim_t e;
        #1 reset = 1'b1;
        exp_q.push_back('{"reset_async", N, mk(24, 24, 3, 6'b000000), FULL});
        #1;
        e = exp_q.pop_front();
        n_chk++;
        if (obs !== e.v)
            $display("FAIL %s: got row=%0d col=%0d lives=%0d flags=%b, expected row=%0d col=%0d lives=%0d flags=%b",
                     e.name, obs[71:40], obs[39:8], obs[7:6], obs[5:0], e.v[71:40], e.v[39:8], e.v[7:6], e.v[5:0]);
        else n_pass++;
        @(posedge pixel_clk); @(posedge pixel_clk); #1 reset = 1'b0;
        s.push_back('{"idle_hold", N, mk(24, 24, 3, 6'b000000), FULL});
        s.push_back('{"idle_tick", T, mk(24, 24, 3, 6'b000000), FULL});
        foreach (s[i]) begin
            apply(s[i].in);
            exp_q.push_back(s[i]);
            @(posedge pixel_clk); #1;
            apply(N);
            e = exp_q.pop_front();
            n_chk++;
            if ((obs & e.mask) !== (e.v & e.mask))
                $display("FAIL %s: got row=%0d col=%0d lives=%0d flags=%b, expected row=%0d col=%0d lives=%0d flags=%b",
                         e.name, obs[71:40], obs[39:8], obs[7:6], obs[5:0], e.v[71:40], e.v[39:8], e.v[7:6], e.v[5:0]);
            else n_pass++;
        end
    endtask

    task automatic test_countdown();
        stim_t s[$];
        stim_t e;
        s.push_back('{"cd_start", S, mk(24, 24, 3, 6'b100000), FULL});
        s.push_back('{"cd_tick1", T, mk(24, 24, 3, 6'b100000), FULL});
        s.push_back('{"cd_gap",   N, mk(24, 24, 3, 6'b100000), FULL});
        s.push_back('{"cd_tick2", T, mk(24, 24, 3, 6'b100000), FULL});
        s.push_back('{"cd_tick3", T, mk(24, 24, 3, 6'b100000), FULL});
        s.push_back('{"cd_tick4", T, mk(24, 24, 3, 6'b000000), FULL});
        for (int unsigned k = 1; k <= 3; k++) begin
            s.push_back('{$sformatf("right%0d", k), T | R, mk(24, 24 + 2 * k, 3, 6'b000010), FULL});
            s.push_back('{$sformatf("right%0d_gap", k), N, mk(24, 24 + 2 * k, 3, 6'b000000), FULL});
        end
        s.push_back('{"right_no_tick", R, mk(24, 30, 3, 6'b000000), FULL});
        foreach (s[i]) begin
            apply(s[i].in);
            exp_q.push_back(s[i]);
            @(posedge pixel_clk); #1;
            apply(N);
            e = exp_q.pop_front();
            n_chk++;
            if ((obs & e.mask) !== (e.v & e.mask))
                $display("FAIL %s: got row=%0d col=%0d lives=%0d flags=%b, expected row=%0d col=%0d lives=%0d flags=%b",
                         e.name, obs[71:40], obs[39:8], obs[7:6], obs[5:0], e.v[71:40], e.v[39:8], e.v[7:6], e.v[5:0]);
            else n_pass++;
        end
    endtask

    task automatic test_clamp();
        stim_t s[$];
        stim_t e;
        for (int unsigned k = 1; k <= 8; k++)
            s.push_back('{$sformatf("up%0d", k), T | U, mk(24 - 2 * k, 30, 3, 6'b000010), FULL});
        s.push_back('{"up_clamp1",  T | U, mk(8, 30, 3, 6'b000000), FULL});
        s.push_back('{"up_clamp2",  T | U, mk(8, 30, 3, 6'b000000), FULL});
        s.push_back('{"updown_right", T | U | D | R, mk(8, 32, 3, 6'b000010), FULL});
        s.push_back('{"down_right", T | D | R, mk(10, 34, 3, 6'b000010), FULL});
        s.push_back('{"up_from10",  T | U, mk(8, 34, 3, 6'b000010), FULL});
        s.push_back('{"up_at8",     T | U, mk(8, 34, 3, 6'b000000), FULL});
        foreach (s[i]) begin
            apply(s[i].in);
            exp_q.push_back(s[i]);
            @(posedge pixel_clk); #1;
            apply(N);
            e = exp_q.pop_front();
            n_chk++;
            if ((obs & e.mask) !== (e.v & e.mask))
                $display("FAIL %s: got row=%0d col=%0d lives=%0d flags=%b, expected row=%0d col=%0d lives=%0d flags=%b",
                         e.name, obs[71:40], obs[39:8], obs[7:6], obs[5:0], e.v[71:40], e.v[39:8], e.v[7:6], e.v[5:0]);
            else n_pass++;
        end
    endtask

    task automatic test_collision();
        stim_t s[$];
        stim_t e;
        s.push_back('{"hit_midframe",  C,     mk(8, 34, 3, 6'b000000), FULL});
        s.push_back('{"hit_tick",      T,     mk(24, 24, 2, 6'b010010), FULL});
        s.push_back('{"delay_gap",     N,     mk(24, 24, 2, 6'b010000), FULL});
        s.push_back('{"hit_in_delay",  C,     mk(24, 24, 2, 6'b010000), FULL});
        s.push_back('{"delay_tick1",   T | D, mk(24, 24, 2, 6'b010000), FULL});
        s.push_back('{"delay_tick2",   T | D, mk(24, 24, 2, 6'b010000), FULL});
        s.push_back('{"delay_tick3",   T | D, mk(24, 24, 2, 6'b000000), FULL});
        s.push_back('{"play_after",    T | R, mk(24, 26, 2, 6'b000010), FULL});
        s.push_back('{"tdn_midframe",  W,     mk(24, 26, 2, 6'b000000), FULL});
        s.push_back('{"hit_and_tdn",   T | C, mk(24, 24, 1, 6'b010010), FULL});
        s.push_back('{"delay2_tick1",  T,     mk(24, 24, 1, 6'b010000), FULL});
        s.push_back('{"delay2_tick2",  T,     mk(24, 24, 1, 6'b010000), FULL});
        s.push_back('{"delay2_tick3",  T,     mk(24, 24, 1, 6'b000000), FULL});
        s.push_back('{"move_pre_win",  T | R, mk(24, 26, 1, 6'b000010), FULL});
        s.push_back('{"touchdown",     T | W | R | S, mk(24, 26, 1, 6'b001000), FULL});
        foreach (s[i]) begin
            apply(s[i].in);
            exp_q.push_back(s[i]);
            @(posedge pixel_clk); #1;
            apply(N);
            e = exp_q.pop_front();
            n_chk++;
            if ((obs & e.mask) !== (e.v & e.mask))
                $display("FAIL %s: got row=%0d col=%0d lives=%0d flags=%b, expected row=%0d col=%0d lives=%0d flags=%b",
                         e.name, obs[71:40], obs[39:8], obs[7:6], obs[5:0], e.v[71:40], e.v[39:8], e.v[7:6], e.v[5:0]);
            else n_pass++;
        end
    endtask

    task automatic test_win_restart();
        stim_t s[$];
        stim_t e;
        s.push_back('{"win_held1",   S,     mk(24, 26, 1, 6'b001000), FULL});
        s.push_back('{"win_held2",   T | S, mk(24, 26, 1, 6'b001000), FULL});
        s.push_back('{"win_release", N,     mk(24, 26, 1, 6'b001000), FULL});
        s.push_back('{"win_restart", S,     mk(24, 24, 3, 6'b100011), FULL});
        s.push_back('{"cd2_gap",     N,     mk(24, 24, 3, 6'b100001), FULL});
        s.push_back('{"cd2_tick1",   T,     mk(24, 24, 3, 6'b100001), FULL});
        s.push_back('{"cd2_tick2",   T,     mk(24, 24, 3, 6'b100001), FULL});
        s.push_back('{"cd2_tick3",   T,     mk(24, 24, 3, 6'b100001), FULL});
        s.push_back('{"cd2_tick4",   T,     mk(24, 24, 3, 6'b000001), FULL});
        foreach (s[i]) begin
            apply(s[i].in);
            exp_q.push_back(s[i]);
            @(posedge pixel_clk); #1;
            apply(N);
            e = exp_q.pop_front();
            n_chk++;
            if ((obs & e.mask) !== (e.v & e.mask))
                $display("FAIL %s: got row=%0d col=%0d lives=%0d flags=%b, expected row=%0d col=%0d lives=%0d flags=%b",
                         e.name, obs[71:40], obs[39:8], obs[7:6], obs[5:0], e.v[71:40], e.v[39:8], e.v[7:6], e.v[5:0]);
            else n_pass++;
        end
    endtask

    task automatic test_lose();
        stim_t s[$];
        stim_t e;
        for (int unsigned lv = 3; lv >= 1; lv--) begin
            s.push_back('{$sformatf("mv_l%0d", lv), T | R, mk(24, 26, 2'(lv), 6'b000011), FULL});
            if (lv > 1) begin
                s.push_back('{$sformatf("hit_l%0d", lv), T | C, mk(24, 24, 2'(lv - 1), 6'b010011), FULL});
                s.push_back('{$sformatf("dly_a_l%0d", lv), T, mk(24, 24, 2'(lv - 1), 6'b010001), FULL});
                s.push_back('{$sformatf("dly_b_l%0d", lv), T, mk(24, 24, 2'(lv - 1), 6'b010001), FULL});
                s.push_back('{$sformatf("dly_c_l%0d", lv), T, mk(24, 24, 2'(lv - 1), 6'b000001), FULL});
            end else begin
                s.push_back('{"last_hit", T | C, mk(24, 24, 0, 6'b000111), FULL});
            end
        end
        s.push_back('{"lose_held",    S, mk(24, 24, 0, 6'b000101), FULL});
        s.push_back('{"lose_release", N, mk(24, 24, 0, 6'b000101), FULL});
        s.push_back('{"lose_restart", S, mk(24, 24, 3, 6'b100001), NOCHG});
        s.push_back('{"cd3_gap",      N, mk(24, 24, 3, 6'b100001), FULL});
        s.push_back('{"cd3_tick1",    T, mk(24, 24, 3, 6'b100001), FULL});
        s.push_back('{"cd3_tick2",    T, mk(24, 24, 3, 6'b100001), FULL});
        s.push_back('{"cd3_tick3",    T, mk(24, 24, 3, 6'b100001), FULL});
        s.push_back('{"cd3_tick4",    T, mk(24, 24, 3, 6'b000001), FULL});
        foreach (s[i]) begin
            apply(s[i].in);
            exp_q.push_back(s[i]);
            @(posedge pixel_clk); #1;
            apply(N);
            e = exp_q.pop_front();
            n_chk++;
            if ((obs & e.mask) !== (e.v & e.mask))
                $display("FAIL %s: got row=%0d col=%0d lives=%0d flags=%b, expected row=%0d col=%0d lives=%0d flags=%b",
                         e.name, obs[71:40], obs[39:8], obs[7:6], obs[5:0], e.v[71:40], e.v[39:8], e.v[7:6], e.v[5:0]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midplay();
        stim_t s[$];
        stim_t e;
        s.push_back('{"mp_move", T | R, mk(24, 26, 3, 6'b000011), FULL});
        s.push_back('{"mp_hit",  T | C, mk(24, 24, 2, 6'b010011), FULL});
        s.push_back('{"mp_dly1", T,     mk(24, 24, 2, 6'b010001), FULL});
        s.push_back('{"mp_dly2", T,     mk(24, 24, 2, 6'b010001), FULL});
        s.push_back('{"mp_dly3", T,     mk(24, 24, 2, 6'b000001), FULL});
        for (int unsigned k = 1; k <= 38; k++)
            s.push_back('{$sformatf("mp_diag%0d", k), T | D | R, mk(24 + 2 * k, 24 + 2 * k, 2, 6'b000011), FULL});
        for (int unsigned k = 1; k <= 50; k++)
            s.push_back('{$sformatf("mp_right%0d", k), T | R, mk(100, 100 + 2 * k, 2, 6'b000011), FULL});
        foreach (s[i]) begin
            apply(s[i].in);
            exp_q.push_back(s[i]);
            @(posedge pixel_clk); #1;
            apply(N);
            e = exp_q.pop_front();
            n_chk++;
            if ((obs & e.mask) !== (e.v & e.mask))
                $display("FAIL %s: got row=%0d col=%0d lives=%0d flags=%b, expected row=%0d col=%0d lives=%0d flags=%b",
                         e.name, obs[71:40], obs[39:8], obs[7:6], obs[5:0], e.v[71:40], e.v[39:8], e.v[7:6], e.v[5:0]);
            else n_pass++;
        end
        exp_q.push_back('{"mp_async_reset", N, mk(24, 24, 3, 6'b000000), FULL});
        reset = 1'b1;
        #2;
        e = exp_q.pop_front();
        n_chk++;
        if (obs !== e.v)
            $display("FAIL %s: got row=%0d col=%0d lives=%0d flags=%b, expected row=%0d col=%0d lives=%0d flags=%b",
                     e.name, obs[71:40], obs[39:8], obs[7:6], obs[5:0], e.v[71:40], e.v[39:8], e.v[7:6], e.v[5:0]);
        else n_pass++;
        @(posedge pixel_clk); #1 reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_clamp();
        test_collision();
        test_win_restart();
        test_lose();
        test_reset_midplay();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/maze_game_ctrl.md
Name: maze_game_ctrl

Overview:
- Frame-rate game sequencer for the maze display path.
- Owns ball position, lives, map selection and the game-phase flags: countdown, isdelay, win, lose, change, map_switch.
- Consumes per-pixel collision/touchdown pulses from the display block and a once-per-frame tick.
- Sits between the button synchronisers and the VGA pixel renderer, clocked by pixel_clk.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- BALL_R, 8, ball radius; clamp margin
- START_ROW, 24, ball row after reset, restart or collision
- START_COL, 24, ball column after reset, restart or collision
- STEP, 2, pixels moved per frame per axis
- LIVES, 3, lives at game start (1..3)
- COUNT_FRAMES, 180, frames spent in COUNTDOWN
- DELAY_FRAMES, 60, frames frozen after a collision

Ports:
- pixel_clk  in  1  clock
- reset  in  1  async active-high reset
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- start  in  1  synchronised start/restart button, level
- btn_up, btn_down, btn_left, btn_right  in  1 each  synchronised direction buttons, level
- collision  in  2  from display; bit0 = ball pixel overlapping barrier
- touchdown  in  2  from display; bit0 = ball pixel overlapping endzone
- currentBallRow  out  32  ball centre row
- currentBallCol  out  32  ball centre column
- countdown  out  1  high in COUNTDOWN
- isdelay  out  1  high in DELAY
- win  out  1  high in WIN
- lose  out  1  high in LOSE
- change  out  1  one-cycle pulse whenever ball position register changes
- map_switch  out  1  selects barrier map; toggles on each WIN→restart
- lives  out  2  remaining lives

Behaviour:
- Reset: asynchronous; takes effect immediately on assertion.
  - State IDLE; ball = (START_ROW, START_COL); lives = LIVES.
  - countdown, isdelay, win, lose, change, map_switch, frame counter and sticky flags all 0.
- Sticky flags:
  - hit_f is set on any cycle with collision[0]=1; tdn_f likewise from touchdown[0].
  - Evaluation at frame_tick uses (flag OR same-cycle input); both flags clear on that edge.
  - Flags are ignored and cleared outside PLAY.
- All state changes, ball moves and counter updates occur only on a pixel_clk edge with frame_tick=1, except IDLE→COUNTDOWN and the WIN/LOSE restart, which act on any edge.
- Outputs are registered: visible the cycle after the deciding edge.
- States:
  - IDLE: start=1 → COUNTDOWN, frame counter = 0.
  - COUNTDOWN: countdown=1; counter increments per tick; on the tick where counter = COUNT_FRAMES-1 → PLAY.
  - PLAY, decided per tick in priority order:
    1. hit → lives-1, ball = start position, change pulse; if new lives = 0 → LOSE, else → DELAY with counter = 0.
    2. touchdown → WIN; ball held.
    3. Otherwise move the ball:
       - row −STEP if up only, +STEP if down only; up+down together = no row move.
       - Column likewise for left/right; both axes may move in the same frame.
       - Result clamped to row ∈ [BALL_R, SCREEN_H-1-BALL_R], col ∈ [BALL_R, SCREEN_W-1-BALL_R].
       - change pulses only if the clamped position differs from the current one.
  - DELAY: isdelay=1; buttons ignored; on the tick where counter = DELAY_FRAMES-1 → PLAY.
  - WIN: win=1; start=1 → COUNTDOWN.
    - Toggles map_switch; lives = LIVES; ball = start position; change pulse.
  - LOSE: lose=1; start=1 → COUNTDOWN.
    - Lives and ball reset as in WIN; map_switch unchanged.
- Start held: a restart requires start to be seen low at least once after entering WIN/LOSE (edge-armed), so a held button does not skip the end screen.
- Arithmetic: ball registers are unsigned 32-bit; subtract-then-clamp must not wrap. Compare before subtracting when row < BALL_R+STEP.
- The frame counter is 8 bits. COUNT_FRAMES and DELAY_FRAMES must each be ≤ 256 and ≥ 1.
- collision[1] and touchdown[1] are unused.

Test Plan:
- Reset mid-PLAY (ball at 100,200, lives 2) → next cycle: IDLE, ball (24,24), lives 3, all flags 0, map_switch 0.
- start pulse, COUNT_FRAMES=4 → countdown=1 for exactly 4 frame_ticks, then PLAY. Holding btn_right for 3 ticks → col 30, row 24, three change pulses.
- In PLAY at row 10, hold btn_up → row clamps at 8 and stays there, no further change pulses. Up+down together → row unchanged.
- Single collision pulse mid-frame → at next tick: lives 3→2, ball (24,24), isdelay=1 for DELAY_FRAMES ticks, buttons ignored, then PLAY. A third collision → lose=1, lives 0.
- Collision and touchdown in same frame → collision path taken (lives-1, no win). Touchdown alone → win=1.
- Restart from WIN with start held from entry: no restart until start is released and pressed again. Then map_switch=1, lives 3, COUNTDOWN.
